ab_alu_datapath: RTL and testbench
==================================

AB_ALU_DATAPATH -- requirements
Module: ab_alu_datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ram_in, input, 4 bits: data from RAM into A.
REQ-004 SHALL have port tmp_in, input, 4 bits: TMP register value, used as a B load source and an ALU operand.
REQ-005 SHALL have port opcode, input, 4 bits: instruction opcode from the instruction register.
REQ-006 SHALL have port la_ram, input, 1 bit: load A from ram_in.
REQ-007 SHALL have port la_b, input, 1 bit: load A from B.
REQ-008 SHALL have port lb_tmp, input, 1 bit: load B from tmp_in.
REQ-009 SHALL have port eu, input, 1 bit: execute ALU operation.
REQ-010 SHALL have ports e_atmp, ea_ram and ea_out, inputs, 1 bit each: enables for the a_to_tmp, a_to_ram and a_to_out outputs.
REQ-011 SHALL have ports a_to_tmp, a_to_ram and a_to_out, outputs, 4 bits each: A value when enabled, else 4'h0.
REQ-012 SHALL have ports a_q and b_q, outputs, 4 bits each: current A and B contents, always driven.
REQ-013 SHALL have port carry, output, 1 bit: registered carry/borrow flag.

Function
REQ-014 A, B and carry SHALL be registers; the enabled outputs SHALL be combinational from A.
REQ-015 A load priority on a rising edge SHALL be: ALU result (eu with an A-destination opcode), then la_b, then la_ram; with none active, A holds.
REQ-016 B load priority SHALL be: ALU result (eu with a B-destination opcode), then lb_tmp; with none active, B holds.
REQ-017 Exchange: with la_b=1 and lb_tmp=1 on the same edge, A SHALL take the old B and B SHALL take tmp_in (the controller has already copied A into TMP).
REQ-018 The ALU opcode map SHALL be: 0010 ADD A,B (A<=A+B); 0100 SUB A,B (A<=A-B); 0101 ADD A,TMP (A<=A+tmp_in); 0110 ADD B,A (B<=B+A).
REQ-019 On an eu edge with an opcode not in REQ-018, A, B and carry SHALL be unchanged.
REQ-020 Arithmetic SHALL be 5-bit internally; the result SHALL be truncated to 4 bits, wrapping modulo 16.
REQ-021 For ADD, carry SHALL be bit 4 of the sum.
REQ-022 For SUB, carry SHALL be 1 when a borrow occurs (A<B), else 0.
REQ-023 carry SHALL update only on an eu edge with a valid arithmetic opcode.
REQ-024 Operands SHALL be the pre-edge register values; the result SHALL be visible on a_q/b_q one cycle after the eu edge.
REQ-025 Simultaneous eu and la_ram SHALL give A the ALU result (REQ-015).

Reset
REQ-026 While reset=1, A, B and carry SHALL be 0 immediately, regardless of clk.
REQ-027 While reset=1, all data outputs SHALL read 0.
REQ-028 A reset asserted mid-operation SHALL abort the operation; no partial result SHALL be kept.
REQ-029 The first load after reset deasserts SHALL occur at the next rising edge.

Configuration
REQ-030 Macro ALU_SUB_EN defined: opcode 0100 SHALL perform SUB per REQ-018 and REQ-022.
REQ-031 Macro ALU_SUB_EN undefined: opcode 0100 SHALL be treated as unknown per REQ-019, and no subtractor logic SHALL be synthesized.

Verification
REQ-032 Program sequence: la_ram with ram_in=1 gives A=1; exchange with tmp_in=1 gives B=1; la_ram with ram_in=3 gives A=3; eu with opcode=0010 gives A=4, carry=0.
REQ-033 Overflow: A=F, B=1, eu with opcode=0010 gives A=0, carry=1.
REQ-034 Subtract (ALU_SUB_EN defined): A=3, B=5, eu with opcode=0100 gives A=E, carry=1; A=5, B=3 gives A=2, carry=0.
REQ-035 Output enables: A=9 with only ea_out=1 gives a_to_out=9, a_to_tmp=0 and a_to_ram=0.
REQ-036 Reset mid-operation: reset pulsed between edges while eu=1 gives A=0, B=0 and carry=0 at once, held until the next edge after release.
REQ-037 Unknown opcode and macro off: eu with opcode=0111, or with opcode=0100 and ALU_SUB_EN undefined, leaves A, B and carry unchanged.

Source files
------------

// File: rtl/ab_alu_datapath.sv
// ab_alu_datapath: 4-bit A/B register pair with a small ALU and a carry flag.
// A and B load from RAM, TMP, each other, or the ALU result. A is fanned out
// to three gated output buses.
// Optional feature: define ALU_SUB_EN to enable opcode 0100 (SUB A,B). Without
// it, 0100 decodes as an unknown opcode and no subtractor is built.
module ab_alu_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ram_in,
  input  logic [3:0] tmp_in,
  input  logic [3:0] opcode,
  input  logic       la_ram,
  input  logic       la_b,
  input  logic       lb_tmp,
  input  logic       eu,
  input  logic       e_atmp,
  input  logic       ea_ram,
  input  logic       ea_out,
  output logic [3:0] a_to_tmp,
  output logic [3:0] a_to_ram,
  output logic [3:0] a_to_out,
  output logic [3:0] a_q,
  output logic [3:0] b_q,
  output logic       carry
);

  typedef enum logic [3:0] {
    OP_ADD_AB = 4'b0010,
    OP_SUB_AB = 4'b0100,
    OP_ADD_AT = 4'b0101,
    OP_ADD_BA = 4'b0110
  } alu_op_e;

  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_carry;

  logic [4:0] w_alu_res;
  logic       w_dst_a;
  logic       w_dst_b;
  logic       w_alu_a_wr;
  logic       w_alu_b_wr;
  logic       w_alu_c_wr;

  // Opcode decode and 5-bit ALU; bit 4 is carry for ADD and borrow for SUB
  always_comb begin
    w_alu_res = '0;
    w_dst_a   = 1'b0;
    w_dst_b   = 1'b0;
    case (opcode)
      OP_ADD_AB: begin
        w_alu_res = {1'b0, r_a} + {1'b0, r_b};
        w_dst_a   = 1'b1;
      end
`ifdef ALU_SUB_EN
      OP_SUB_AB: begin
        // 5-bit wrap puts the borrow in bit 4 exactly when A < B
        w_alu_res = {1'b0, r_a} - {1'b0, r_b};
        w_dst_a   = 1'b1;
      end
`endif
      OP_ADD_AT: begin
        w_alu_res = {1'b0, r_a} + {1'b0, tmp_in};
        w_dst_a   = 1'b1;
      end
      OP_ADD_BA: begin
        w_alu_res = {1'b0, r_b} + {1'b0, r_a};
        w_dst_b   = 1'b1;
      end
      default: begin
        w_alu_res = '0;
        w_dst_a   = 1'b0;
        w_dst_b   = 1'b0;
      end
    endcase
  end

  assign w_alu_a_wr = eu & w_dst_a;
  assign w_alu_b_wr = eu & w_dst_b;
  assign w_alu_c_wr = w_alu_a_wr | w_alu_b_wr;

  // A register: ALU result beats la_b, which beats la_ram
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
    end else if (w_alu_a_wr) begin
      r_a <= w_alu_res[3:0];
    end else if (la_b) begin
      r_a <= r_b;
    end else if (la_ram) begin
      r_a <= ram_in;
    end
  end

  // B register: ALU result beats lb_tmp; with la_b this forms the A/B exchange
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b <= '0;
    end else if (w_alu_b_wr) begin
      r_b <= w_alu_res[3:0];
    end else if (lb_tmp) begin
      r_b <= tmp_in;
    end
  end

  // Carry flag: only touched by a recognised arithmetic operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry <= 1'b0;
    end else if (w_alu_c_wr) begin
      r_carry <= w_alu_res[4];
    end
  end

  assign a_q      = r_a;
  assign b_q      = r_b;
  assign carry    = r_carry;
  assign a_to_tmp = e_atmp ? r_a : '0;
  assign a_to_ram = ea_ram ? r_a : '0;
  assign a_to_out = ea_out ? r_a : '0;

endmodule

// File: tb/tb_ab_alu_datapath.sv
// Bench for ab_alu_datapath: directed program sequence with literal
// expectations, then randomized traffic against an integer reference model.
module tb_ab_alu_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ram_in, tmp_in, opcode;
  logic       la_ram, la_b, lb_tmp, eu;
  logic       e_atmp, ea_ram, ea_out;
  logic [3:0] a_to_tmp, a_to_ram, a_to_out, a_q, b_q;
  logic       carry;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state
  int m_a, m_b, m_c;

  ab_alu_datapath dut (
    .clk(clk), .reset(reset), .ram_in(ram_in), .tmp_in(tmp_in), .opcode(opcode),
    .la_ram(la_ram), .la_b(la_b), .lb_tmp(lb_tmp), .eu(eu),
    .e_atmp(e_atmp), .ea_ram(ea_ram), .ea_out(ea_out),
    .a_to_tmp(a_to_tmp), .a_to_ram(a_to_ram), .a_to_out(a_to_out),
    .a_q(a_q), .b_q(b_q), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: what A, B and carry must become on each clock edge
  always @(posedge clk or posedge reset) begin
    int s;
    bit alu_a, alu_b;
    if (reset) begin
      m_a = 0; m_b = 0; m_c = 0;
    end else begin
      alu_a = 0; alu_b = 0; s = 0;
      if (eu) begin
        case (opcode)
          4'd2: begin s = m_a + m_b;    alu_a = 1; end
          4'd5: begin s = m_a + tmp_in; alu_a = 1; end
          4'd6: begin s = m_b + m_a;    alu_b = 1; end
`ifdef ALU_SUB_EN
          4'd4: begin s = m_a - m_b;    alu_a = 1; end
`endif
          default: ;
        endcase
      end
      if (alu_a || alu_b) begin
        m_c = (s > 15 || s < 0) ? 1 : 0;
        s = (s + 16) % 16;
      end
      if (alu_a) m_a = s;
      else if (la_b) m_a = m_b;
      else if (la_ram) m_a = ram_in;
      if (alu_b) m_b = s;
      else if (lb_tmp) m_b = tmp_in;
    end
  end

  // Compare process: every falling edge, DUT vs model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_a", a_q, 4'(m_a));
      check("model_b", b_q, 4'(m_b));
      check("model_carry", {3'b0, carry}, 4'(m_c));
      check("model_a_to_tmp", a_to_tmp, e_atmp ? 4'(m_a) : 4'h0);
      check("model_a_to_ram", a_to_ram, ea_ram ? 4'(m_a) : 4'h0);
      check("model_a_to_out", a_to_out, ea_out ? 4'(m_a) : 4'h0);
    end
  end

  task automatic set_in(input logic lr, input logic [3:0] rv, input logic lbv,
                        input logic lt, input logic [3:0] tv, input logic ev,
                        input logic [3:0] ov);
    la_ram = lr; ram_in = rv; la_b = lbv; lb_tmp = lt; tmp_in = tv; eu = ev; opcode = ov;
  endtask

  // advance through one rising edge to the following falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_abc(input string name, input logic [3:0] ea, input logic [3:0] eb,
                         input logic ec);
    check({name, "_a"}, a_q, ea);
    check({name, "_b"}, b_q, eb);
    check({name, "_carry"}, {3'b0, carry}, {3'b0, ec});
  endtask

  initial begin
    reset = 1'b1;
    e_atmp = 1'b0; ea_ram = 1'b0; ea_out = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    cmp_en = 1'b1;
    chk_abc("reset", 4'h0, 4'h0, 1'b0);
    #1 reset = 1'b0;

    // program sequence
    set_in(1, 4'h1, 0, 0, 0, 0, 0);           step(); chk_abc("load_a1", 4'h1, 4'h0, 0);
    #1 set_in(0, 0, 1, 1, 4'h1, 0, 0);        step(); chk_abc("exchange", 4'h0, 4'h1, 0);
    #1 set_in(1, 4'h3, 0, 0, 0, 0, 0);        step(); chk_abc("load_a3", 4'h3, 4'h1, 0);
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0010);     step(); chk_abc("add_ab", 4'h4, 4'h1, 0);

    // overflow
    #1 set_in(1, 4'hF, 0, 0, 0, 0, 0);        step();
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0010);     step(); chk_abc("overflow", 4'h0, 4'h1, 1);

    // unknown opcode leaves everything alone
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0111);     step(); chk_abc("unknown_op", 4'h0, 4'h1, 1);

    // subtract (or unknown when the feature is absent)
    #1 set_in(1, 4'h3, 0, 1, 4'h5, 0, 0);     step();
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0100);     step();
`ifdef ALU_SUB_EN
    chk_abc("sub_borrow", 4'hE, 4'h5, 1);
`else
    chk_abc("sub_off", 4'h3, 4'h5, 1);
`endif
    #1 set_in(1, 4'h5, 0, 1, 4'h3, 0, 0);     step();
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0100);     step();
`ifdef ALU_SUB_EN
    chk_abc("sub_noborrow", 4'h2, 4'h3, 0);
`else
    chk_abc("sub_off2", 4'h5, 4'h3, 1);
`endif

    // ALU result wins over la_ram; ADD A,TMP then ADD B,A
    #1 set_in(1, 4'h9, 0, 1, 4'h3, 0, 0);     step();
    #1 set_in(1, 4'h1, 0, 0, 4'h8, 1, 4'b0101); step(); chk_abc("eu_vs_laram", 4'h1, 4'h3, 1);
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0110);     step(); chk_abc("add_ba", 4'h1, 4'h4, 0);

    // output enables
    #1 set_in(1, 4'h9, 0, 0, 0, 0, 0); ea_out = 1'b1; step();
    check("en_out", a_to_out, 4'h9);
    check("en_tmp", a_to_tmp, 4'h0);
    check("en_ram", a_to_ram, 4'h0);

    // reset asserted between edges while an ADD is pending
    #1 set_in(0, 0, 0, 0, 0, 1, 4'b0010);
    #2 reset = 1'b1;
    #1 chk_abc("rst_async", 4'h0, 4'h0, 0);
    check("rst_out", a_to_out, 4'h0);
    step(); chk_abc("rst_held", 4'h0, 4'h0, 0);
    #1 reset = 1'b0; set_in(1, 4'h7, 0, 0, 0, 0, 0);
    #1 chk_abc("rst_release", 4'h0, 4'h0, 0);
    step(); chk_abc("first_load", 4'h7, 4'h0, 0);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      #1;
      reset  = ($urandom_range(0, 63) == 0);
      la_ram = $urandom_range(0, 1);
      la_b   = ($urandom_range(0, 3) == 0);
      lb_tmp = $urandom_range(0, 1);
      eu     = $urandom_range(0, 1);
      ram_in = 4'($urandom);
      tmp_in = 4'($urandom);
      case ($urandom_range(0, 4))
        0: opcode = 4'b0010;
        1: opcode = 4'b0100;
        2: opcode = 4'b0101;
        3: opcode = 4'b0110;
        default: opcode = 4'($urandom);
      endcase
      e_atmp = $urandom_range(0, 1);
      ea_ram = $urandom_range(0, 1);
      ea_out = $urandom_range(0, 1);
      step();
    end

    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
